fpu_operand_loader: RTL

FPU_OPERAND_LOADER -- requirements
Module: fpu_operand_loader

---
 rtl/fpu_operand_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fpu_operand_loader.sv
// Assembles two 16-bit FPU operands from four nibble pairs per framed burst.
// Completed pairs are presented to the core with a valid/ready handshake.
module fpu_operand_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  nib_a,
  input  logic [3:0]  nib_b,
  input  logic        sel,
  input  logic        in_en,
  input  logic        op_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_sel,
  output logic        op_valid,
  output logic        busy,
  output logic        abort,
  output logic [1:0]  dbg_state
);

  // Handshake: a pair transfers on an edge where op_valid and op_ready are both
  // high; until then op_a/op_b/op_sel hold steady and op_valid stays asserted.
  typedef enum logic [1:0] {IDLE, LEAD, LOAD, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic        sh_sel_q, sh_sel_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic        op_sel_q, op_sel_d;
  logic        op_valid_q, op_valid_d;
  logic        busy_q, busy_d;
  logic        abort_q, abort_d;
  logic        en_prev_q, en_prev_d;
  logic [15:0] asm_a, asm_b;

  // Shadows with the current nibble merged in at the counter position.
  always_comb begin
    asm_a = sh_a_q;
    asm_b = sh_b_q;
    case (cnt_q)
      2'd0: begin asm_a[3:0]   = nib_a; asm_b[3:0]   = nib_b; end
      2'd1: begin asm_a[7:4]   = nib_a; asm_b[7:4]   = nib_b; end
      2'd2: begin asm_a[11:8]  = nib_a; asm_b[11:8]  = nib_b; end
      default: begin asm_a[15:12] = nib_a; asm_b[15:12] = nib_b; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    sh_sel_d   = sh_sel_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    op_valid_d = op_valid_q;
    abort_d    = 1'b0;
    en_prev_d  = in_en;

    if (op_valid_q && op_ready) op_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_en && !en_prev_q) begin
          state_d  = LEAD;
          sh_sel_d = sel;
        end
      end
      LEAD: begin
        if (in_en) begin
          state_d = LOAD;
          cnt_d   = 2'd0;
        end else begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      LOAD: begin
        if (in_en) begin
          sh_a_d = asm_a;
          sh_b_d = asm_b;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = HOLD;
            // A still-pending, unaccepted pair wins over the new frame.
            if (op_valid_q && !op_ready) begin
              abort_d = 1'b1;
            end else begin
              op_a_d     = asm_a;
              op_b_d     = asm_b;
              op_sel_d   = sh_sel_q;
              op_valid_d = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      default: begin
        if (!in_en) state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) || op_valid_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      sh_a_q     <= 16'h0;
      sh_b_q     <= 16'h0;
      sh_sel_q   <= 1'b0;
      op_a_q     <= 16'h0;
      op_b_q     <= 16'h0;
      op_sel_q   <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      en_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      sh_sel_q   <= sh_sel_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      en_prev_q  <= en_prev_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_sel    = op_sel_q;
  assign op_valid  = op_valid_q;
  assign busy      = busy_q;
  assign abort     = abort_q;
  assign dbg_state = state_q;

endmodule
